// File: rtl/eda_task_fifo_ctrl_if.sv
// Handshake and FIFO-side bundle for the eda_task FIFO controller.
// slave = controller view, master = environment (producers, FIFO, consumer).
interface eda_task_fifo_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              A_VALID;
  logic [DATA_W-1:0] A_DATA;
  logic              A_READY;
  logic              B_VALID;
  logic [DATA_W-1:0] B_DATA;
  logic              B_READY;
  logic              FIFO_WR_EN;
  logic [DATA_W-1:0] FIFO_DIN;
  logic              FIFO_FULL;
  logic              FIFO_RD_EN;
  logic [DATA_W-1:0] FIFO_DOUT;
  logic              FIFO_EMPTY;
  logic              OUT_VALID;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_READY;
  logic              OWNER;

  modport slave (
    input  A_VALID, A_DATA, B_VALID, B_DATA, FIFO_FULL, FIFO_DOUT, FIFO_EMPTY, OUT_READY,
    output A_READY, B_READY, FIFO_WR_EN, FIFO_DIN, FIFO_RD_EN, OUT_VALID, OUT_DATA, OWNER
  );

  modport master (
    output A_VALID, A_DATA, B_VALID, B_DATA, FIFO_FULL, FIFO_DOUT, FIFO_EMPTY, OUT_READY,
    input  A_READY, B_READY, FIFO_WR_EN, FIFO_DIN, FIFO_RD_EN, OUT_VALID, OUT_DATA, OWNER
  );
endinterface

// File: rtl/eda_task_fifo_ctrl.sv
// eda_task FIFO controller.
// Write side: round-robin arbitration between producers A and B with a burst
// limit, feeding the FIFO write port. Read side: a three-state sequencer that
// drives the FIFO's registered read port and presents words as valid/ready.
module eda_task_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 SYSCLK,
  input  logic                 RST_B,
  eda_task_fifo_ctrl_if.slave  bus
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;

  // Write arbitration state
  logic        owner_q, owner_d;
  logic [3:0]  burst_q, burst_d;

  // Read sequencer state and registered outputs
  rd_state_e         state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic              own_valid, oth_valid;
  logic              grant_own, grant_oth;
  logic              grant_a, grant_b;
  logic              acc_a, acc_b, wr_en, rd_en;
  logic [DATA_W-1:0] din;

  // Grant, acceptance and next arbitration state; all gated off in reset
  always_comb begin
    own_valid = owner_q ? bus.B_VALID : bus.A_VALID;
    oth_valid = owner_q ? bus.A_VALID : bus.B_VALID;
    // Owner keeps the port until its burst is used up, unless nobody else wants it
    grant_own = own_valid && ((burst_q < MAX_B) || !oth_valid);
    grant_oth = !grant_own && oth_valid;
    grant_a   = owner_q ? grant_oth : grant_own;
    grant_b   = owner_q ? grant_own : grant_oth;
    // FULL only blocks acceptance; the grant itself is unaffected
    acc_a     = RST_B && grant_a && !bus.FIFO_FULL;
    acc_b     = RST_B && grant_b && !bus.FIFO_FULL;
    wr_en     = acc_a || acc_b;

    din = '0;
    if (RST_B) begin
      if (grant_a)      din = bus.A_DATA;
      else if (grant_b) din = bus.B_DATA;
    end

    owner_d = owner_q;
    burst_d = burst_q;
    if (wr_en) begin
      if (grant_own) begin
        burst_d = (burst_q >= MAX_B) ? MAX_B : burst_q + 4'd1;
      end else begin
        owner_d = !owner_q;
        burst_d = 4'd1;
      end
    end

    // Never read an empty FIFO; re-fetch straight from HOLD when consumed
    rd_en = RST_B && !bus.FIFO_EMPTY &&
            ((state_q == IDLE) || ((state_q == HOLD) && bus.OUT_READY));
  end

  // Arbitration registers: ownership and beats won in the current burst
  always_ff @(posedge SYSCLK) begin
    if (!RST_B) begin
      owner_q <= 1'b0;
      burst_q <= 4'd0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // Read sequencer: issue RD_EN, capture FIFO data one cycle later, hold until taken
  always_ff @(posedge SYSCLK) begin
    if (!RST_B) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_en) state_q <= FETCH;
        end
        FETCH: begin
          out_data_q  <= bus.FIFO_DOUT;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= rd_en ? FETCH : IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.A_READY    = acc_a;
  assign bus.B_READY    = acc_b;
  assign bus.FIFO_WR_EN = wr_en;
  assign bus.FIFO_DIN   = din;
  assign bus.FIFO_RD_EN = rd_en;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.OUT_DATA   = out_data_q;
  assign bus.OWNER      = owner_q;

endmodule

// File: tb/tb_eda_task_fifo_ctrl.sv
// Bench for eda_task_fifo_ctrl: producer models, a behavioural 16-deep FIFO
// with registered read, a write/read scoreboard and directed timing checks.
module tb_eda_task_fifo_ctrl;

  localparam int DATA_W = 8;

  logic SYSCLK = 1'b0;
  logic RST_B  = 1'b0;

  eda_task_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

  eda_task_fifo_ctrl #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .SYSCLK (SYSCLK),
    .RST_B  (RST_B),
    .bus    (bus.slave)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed {
    logic       owner;  // OWNER expected during the beat
    logic       src;    // 0 = A, 1 = B
    logic [7:0] data;
  } wr_t;

  wr_t        wr_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic force_full = 1'b0;
  logic hold_empty = 1'b0;

  // Behavioural FIFO with registered read port, shares RST_B
  logic [7:0] fmem [0:15];
  logic [4:0] fcnt;
  logic [3:0] fwp, frp;
  logic [7:0] fdout;

  always @(posedge SYSCLK) begin
    if (!RST_B) begin
      fcnt  <= '0;
      fwp   <= '0;
      frp   <= '0;
      fdout <= '0;
    end else begin
      if (bus.FIFO_WR_EN) begin
        fmem[fwp] <= bus.FIFO_DIN;
        fwp       <= fwp + 4'd1;
      end
      if (bus.FIFO_RD_EN) begin
        fdout <= fmem[frp];
        frp   <= frp + 4'd1;
      end
      fcnt <= fcnt + 5'(bus.FIFO_WR_EN) - 5'(bus.FIFO_RD_EN);
    end
  end

  assign bus.FIFO_FULL  = (fcnt == 5'd16) || force_full;
  assign bus.FIFO_EMPTY = (fcnt == 5'd0)  || hold_empty;
  assign bus.FIFO_DOUT  = fdout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic exp_wr(input logic own, input logic src, input logic [7:0] d, input bit with_rd);
    wr_t e;
    e.owner = own;
    e.src   = src;
    e.data  = d;
    wr_exp.push_back(e);
    if (with_rd) rd_exp.push_back(d);
  endtask

  task automatic do_reset();
    tick();
    RST_B = 1'b0;
    tick();
    tick();
    RST_B = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (wr_exp.size() == 0 && rd_exp.size() == 0 && a_q.size() == 0 && b_q.size() == 0) break;
      tick();
    end
    chk("drain_left", 32'(wr_exp.size() + rd_exp.size() + a_q.size() + b_q.size()), 32'd0);
  endtask

  // Producers: present queue head, pop after an accepted beat
  initial begin
    logic acc_a, acc_b;
    bus.A_VALID = 1'b0;
    bus.A_DATA  = '0;
    bus.B_VALID = 1'b0;
    bus.B_DATA  = '0;
    forever begin
      @(negedge SYSCLK);
      acc_a = bus.A_VALID && bus.A_READY;
      acc_b = bus.B_VALID && bus.B_READY;
      @(posedge SYSCLK);
      #2;
      if (acc_a && a_q.size() != 0) void'(a_q.pop_front());
      if (acc_b && b_q.size() != 0) void'(b_q.pop_front());
      bus.A_VALID = (a_q.size() != 0);
      bus.A_DATA  = (a_q.size() != 0) ? a_q[0] : 8'h00;
      bus.B_VALID = (b_q.size() != 0);
      bus.B_DATA  = (b_q.size() != 0) ? b_q[0] : 8'h00;
    end
  end

  // Monitor: pop and compare every write beat and every consumed output word
  initial begin
    wr_t        e;
    logic [7:0] d;
    forever begin
      @(negedge SYSCLK);
      if (RST_B) begin
        if (bus.FIFO_WR_EN) begin
          if (wr_exp.size() == 0) begin
            chk("wr_unexpected", {22'd0, bus.OWNER, bus.B_READY, bus.FIFO_DIN}, 32'hFFFF_FFFF);
          end else begin
            e = wr_exp.pop_front();
            chk("wr_beat", {22'd0, bus.OWNER, bus.B_READY, bus.A_READY, bus.FIFO_DIN},
                {22'd0, e.owner, e.src, ~e.src, e.data});
          end
        end
        if (bus.OUT_VALID && bus.OUT_READY) begin
          if (rd_exp.size() == 0) begin
            chk("rd_unexpected", {24'd0, bus.OUT_DATA}, 32'hFFFF_FFFF);
          end else begin
            d = rd_exp.pop_front();
            chk("rd_word", {24'd0, bus.OUT_DATA}, {24'd0, d});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] m_rd, m_ov;
    logic [4:0] m_a;
    bus.OUT_READY = 1'b1;

    // 1. Reset with both producers requesting
    a_q.push_back(8'hA1);
    b_q.push_back(8'hB1);
    tick();
    tick();
    @(negedge SYSCLK);
    chk("rst_ready", {30'd0, bus.A_READY, bus.B_READY}, 32'd0);
    chk("rst_wr", {31'd0, bus.FIFO_WR_EN}, 32'd0);
    chk("rst_din", {24'd0, bus.FIFO_DIN}, 32'd0);
    chk("rst_rd", {31'd0, bus.FIFO_RD_EN}, 32'd0);
    chk("rst_out", {23'd0, bus.OUT_VALID, bus.OUT_DATA}, 32'd0);
    chk("rst_owner", {31'd0, bus.OWNER}, 32'd0);
    exp_wr(1'b0, 1'b0, 8'hA1, 1'b1);
    exp_wr(1'b0, 1'b1, 8'hB1, 1'b1);
    tick();
    RST_B = 1'b1;
    @(negedge SYSCLK);
    chk("owner_after_rst", {31'd0, bus.OWNER}, 32'd0);
    wait_drain();

    // 2. A alone: three back-to-back beats
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      d = 8'(i);
      a_q.push_back(d);
      exp_wr(1'b0, 1'b0, d, 1'b1);
    end
    m_a = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge SYSCLK);
      m_a[i] = bus.A_READY && bus.FIFO_WR_EN;
    end
    chk("a_only_ready_mask", {27'd0, m_a}, 32'h07);
    wait_drain();

    // 3. Contention: four beats each, alternating ownership
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      a_q.push_back(d);
      d = 8'h20 + 8'(i);
      b_q.push_back(d);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'h10 + 8'(i);
      exp_wr(1'b0, 1'b0, d, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'h20 + 8'(i);
      exp_wr((i != 0), 1'b1, d, 1'b1);
    end
    for (int i = 4; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      exp_wr((i == 4), 1'b0, d, 1'b1);
    end
    for (int i = 4; i < 8; i++) begin
      d = 8'h20 + 8'(i);
      exp_wr((i != 4), 1'b1, d, 1'b1);
    end
    wait_drain();
    chk("contention_final_owner", {31'd0, bus.OWNER}, 32'd1);

    // 4. FIFO full mid-burst: acceptance stops, burst count holds
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = 8'h30 + 8'(i);
      a_q.push_back(d);
      exp_wr(1'b0, 1'b0, d, 1'b1);
    end
    b_q.push_back(8'h40);
    exp_wr(1'b0, 1'b1, 8'h40, 1'b1);
    tick();
    tick();
    force_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge SYSCLK);
      chk("full_blocks", {30'd0, bus.A_READY, bus.FIFO_WR_EN}, 32'd0);
      chk("full_burst_hold", {28'd0, dut.burst_q}, 32'd2);
    end
    tick();
    force_full = 1'b0;
    @(negedge SYSCLK);
    chk("full_resume", {22'd0, bus.A_READY, bus.FIFO_WR_EN, bus.FIFO_DIN}, {22'd0, 2'b11, 8'h32});
    wait_drain();

    // 5. Drain three words with the consumer always ready
    do_reset();
    hold_empty = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      d = 8'(i);
      a_q.push_back(d);
      exp_wr(1'b0, 1'b0, d, 1'b1);
    end
    repeat (6) tick();
    hold_empty = 1'b0;
    m_rd = '0;
    m_ov = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge SYSCLK);
      m_rd[i] = bus.FIFO_RD_EN;
      m_ov[i] = bus.OUT_VALID;
    end
    chk("drain_rd_en_pattern", {24'd0, m_rd}, 32'h15);
    chk("drain_out_valid_pattern", {24'd0, m_ov}, 32'h54);
    chk("drain_idle", {30'd0, dut.state_q}, 32'd0);
    wait_drain();

    // 6. Backpressure in HOLD, then reset while holding
    do_reset();
    bus.OUT_READY = 1'b0;
    hold_empty = 1'b1;
    a_q.push_back(8'h55);
    a_q.push_back(8'h66);
    exp_wr(1'b0, 1'b0, 8'h55, 1'b0);
    exp_wr(1'b0, 1'b0, 8'h66, 1'b0);
    repeat (5) tick();
    hold_empty = 1'b0;
    @(negedge SYSCLK);
    @(negedge SYSCLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge SYSCLK);
      chk("bp_hold", {22'd0, bus.OUT_VALID, bus.FIFO_RD_EN, bus.OUT_DATA}, {22'd0, 2'b10, 8'h55});
    end
    tick();
    RST_B = 1'b0;
    tick();
    @(negedge SYSCLK);
    chk("bp_reset_clears", {22'd0, bus.OUT_VALID, bus.FIFO_RD_EN, bus.OUT_DATA}, 32'd0);
    tick();
    RST_B = 1'b1;
    bus.OUT_READY = 1'b1;
    m_ov = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge SYSCLK);
      m_ov[i] = bus.OUT_VALID;
    end
    chk("bp_no_valid_after_reset", {24'd0, m_ov}, 32'd0);
    chk("bp_wr_consumed", 32'(wr_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
